// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-slot registers: state encoding and default widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int unsigned PIPE_DATA_W = 73;
    localparam int unsigned PIPE_CTRL_W = 4;
    localparam int unsigned PIPE_CNT_W  = 16;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register with registered ready/valid, flush,
// bubble-as-NOP output masking and a saturating stall counter.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned CTRL_W = PIPE_CTRL_W,
    parameter int unsigned CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    skid_state_t       state;
    skid_state_t       state_nxt;
    logic [DATA_W-1:0] main_entry;
    logic [DATA_W-1:0] skid_entry;
    logic              in_fire;
    logic              out_fire;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // An empty slot presents its control bits as zero so downstream sees a NOP.
    always_comb begin
        out_data = main_entry;
        if (!out_valid) begin
            out_data[DATA_W-1 -: CTRL_W] = '0;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush overrides any transfer in the same cycle; offered data is dropped.
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            main_entry <= '0;
            skid_entry <= '0;
            stall_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (load_main_in) begin
                main_entry <= in_data;
            end else if (load_main_skid) begin
                main_entry <= skid_entry;
            end
            if (load_skid) begin
                skid_entry <= in_data;
            end
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: occupancy model plus expected-data queue.
module tb_pipe_skid_reg;

    localparam int unsigned DATA_W = 73;
    localparam int unsigned CTRL_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_ready;
    logic              in_ready, out_valid;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       stall_cnt;
    logic              in_ready4, out_valid4;
    logic [DATA_W-1:0] out_data4;
    logic [3:0]        stall_cnt4;

    int unsigned       vectors = 0;
    int unsigned       miscompares = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [15:0]       exp_cnt = '0;
    logic [3:0]        exp_cnt4 = '0;
    logic              acc;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(73), .CTRL_W(4), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .stall_cnt(stall_cnt)
    );

    pipe_skid_reg #(.DATA_W(73), .CTRL_W(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .flush(flush), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .stall_cnt(stall_cnt4)
    );

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[DATA_W-1:0];
    endfunction

    task automatic check_outputs();
        logic [DATA_W-1:0] od, od4;
        chk("in_ready", in_ready, exp_q.size() < 2);
        chk("out_valid", out_valid, exp_q.size() > 0);
        chk("in_ready4", in_ready4, exp_q.size() < 2);
        chk("out_valid4", out_valid4, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            chk("out_data", out_data, exp_q[0]);
            chk("out_data4", out_data4, exp_q[0]);
        end else begin
            od  = out_data;
            od4 = out_data4;
            chk("bubble_ctrl", od[DATA_W-1 -: CTRL_W], '0);
            chk("bubble_ctrl4", od4[DATA_W-1 -: CTRL_W], '0);
        end
        chk("stall_cnt", stall_cnt, exp_cnt);
        chk("stall_cnt4", stall_cnt4, exp_cnt4);
    endtask

    // Drive one cycle, check the outputs left by the previous edge, advance the model.
    task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
        logic ofire;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        check_outputs();
        acc   = iv && (exp_q.size() < 2) && !fl;
        ofire = ordy && (exp_q.size() > 0);
        if (exp_q.size() > 0 && !ordy) begin
            if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
            if (exp_cnt4 != '1) exp_cnt4 = exp_cnt4 + 1'b1;
        end
        if (fl) begin
            exp_q.delete();
        end else begin
            if (ofire) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 6 && exp_q.size() > 0; i++) step(1'b0, rnd(), 1'b1, 1'b0);
        chk("drained", exp_q.size() == 0, 1'b1);
        step(1'b0, rnd(), 1'b1, 1'b0);
    endtask

    task automatic fill_full();
        step(1'b1, rnd(), 1'b0, 1'b0);
        step(1'b1, rnd(), 1'b0, 1'b0);
        chk("full_in_ready", in_ready, 1'b0);
    endtask

    initial begin
        int unsigned idx;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_data", out_data, '0);
        chk("rst_stall", stall_cnt, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single transfer, one-cycle latency, then back-to-back streaming.
        step(1'b1, 73'h1_0000_0005_0000_0007, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, rnd(), 1'b1, 1'b0);
        drain();

        // Eight entries with out_ready low for cycles 2-4; in_valid dropped while full.
        idx = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            step((idx < 8) && (cyc != 3), rnd(), !(cyc >= 2 && cyc <= 4), 1'b0);
            if (acc) idx++;
        end
        chk("stream_accepted", idx, 8);
        chk("stream_stall3", stall_cnt, 16'd3);
        drain();

        // Flush from FULL with a new entry offered.
        fill_full();
        step(1'b1, {4'hF, 69'h1BAD_BAD_BAD_BAD_BAD}, 1'b0, 1'b1);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        step(1'b1, rnd(), 1'b1, 1'b0);
        step(1'b1, rnd(), 1'b1, 1'b0);
        drain();

        // Long stall: the 4-bit counter saturates and holds.
        step(1'b1, rnd(), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, rnd(), 1'b0, 1'b0);
        chk("sat_cnt4", stall_cnt4, 4'hF);
        drain();

        // Asynchronous reset between edges while FULL, then restart.
        fill_full();
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_out_data", out_data, '0);
        chk("arst_stall", stall_cnt, '0);
        chk("arst_stall4", stall_cnt4, '0);
        exp_q.delete();
        exp_cnt  = '0;
        exp_cnt4 = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b1, rnd(), 1'b1, 1'b0);
        step(1'b1, rnd(), 1'b0, 1'b0);
        step(1'b0, rnd(), 1'b1, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
